uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Frame controller behind uart_receive. Consumes its byte stream (dataOut + finished_read)
//  and parses frames: SOF, LEN, LEN payload bytes, XOR checksum. Good frames are committed to
//  a readable payload bank. Bad or stalled frames are dropped and flagged.
//  Sits between uart_receive and the top-level output mux in tt_um_njzhu_uart.
// PARAMETERS
//  CLK_HZ        50_000_000  system clock frequency (Hz)
//  BAUD          9600        UART bit rate; byte time BT = 10*CLK_HZ/BAUD cycles
//  SOF           8'hA5       start-of-frame byte
//  MAX_LEN       8           max payload bytes (>=1); ADDR_W = $clog2(MAX_LEN), min 1
//  TIMEOUT_BYTES 4           inter-byte timeout inside a frame = TIMEOUT_BYTES*BT cycles
// PORTS
//  clock       in   1       system clock, all state on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  byte_in     in   8       received byte (uart_receive dataOut)
//  byte_valid  in   1       uart_receive finished_read; only its rising edge is used
//  rd_addr     in   ADDR_W  committed-bank read index
//  rd_data     out  8       committed bank[rd_addr], combinational; 0 if rd_addr>=MAX_LEN
//  frame_len   out  4       LEN of last committed frame
//  frame_ok    out  1       1-cycle pulse: frame committed
//  frame_err   out  1       1-cycle pulse: frame dropped
//  err_code    out  2       01 bad LEN, 10 checksum mismatch, 11 timeout; holds until next err
//  busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE; bank, shadow, frame_len, err_code, checksum, counters = 0;
//    frame_ok=frame_err=busy=0; edge-detect register=0. A reset mid-frame discards the frame.
//  - Accept: byte accepted in cycle where byte_valid=1 and registered byte_valid_d=0.
//    byte_valid held high is one byte. byte_valid already high out of reset is not accepted.
//  - FSM (one transition per accepted byte unless noted):
//    IDLE: byte==SOF -> LEN; any other byte ignored, no flags.
//    LEN: 1<=byte<=MAX_LEN -> store len, csum=byte, idx=0 -> PAYLOAD;
//         else frame_err, err_code=01 -> IDLE.
//         An SOF-valued byte here is treated as LEN (no resync).
//    PAYLOAD: shadow[idx]=byte, csum^=byte, idx++; after byte len-1 -> CHECK.
//    CHECK: byte==csum -> copy shadow[0..len-1] into bank, zero bank[len..MAX_LEN-1],
//           frame_len=len, frame_ok -> IDLE. Else frame_err, err_code=10 -> IDLE.
//  - Latency: frame_ok/frame_err/bank/frame_len update on the clock edge ending the
//    acceptance cycle. Pulses are high for exactly that next cycle.
//  - Failed frames never modify the bank or frame_len. Bank holds until the next good frame.
//  - Timeout: counter cleared on entry to LEN and on every accepted byte.
//    Increments each cycle while busy. Reaching TIMEOUT_BYTES*BT-1 -> frame_err,
//    err_code=11 -> IDLE. If a byte is accepted in the expiry cycle, the byte wins.
//  - Back-to-back frames: SOF may arrive the cycle after CHECK returns to IDLE.
//  - Width: csum 8-bit XOR. idx ADDR_W+1 bits, no wrap (bounded by len). Timeout counter
//    is $clog2(TIMEOUT_BYTES*BT)+1 bits and saturates.
// TESTING
//  1. Good frame: bytes A5 03 11 22 33 03 -> frame_ok 1 pulse; frame_len=3;
//     rd_data[0..2]=11,22,33; rd_data[3..7]=00; busy low after.
//  2. Bad checksum: A5 02 AA BB 00 -> frame_err, err_code=10; bank/frame_len unchanged from test 1.
//  3. Bad LEN: A5 00 and A5 09 -> frame_err, err_code=01 each; FSM back to IDLE; next good frame passes.
//  4. Timeout: A5 02 11 then idle 4*52083 cycles -> frame_err, err_code=11 at expiry. With a byte
//     accepted exactly at the expiry cycle -> no error, frame continues.
//  5. Noise + level strobe: 00 FF 5A before A5 01 7E 7F; byte_valid held high 100 cycles per byte
//     -> noise ignored, each byte counted once, frame_ok, rd_data[0]=7E.
//  6. Reset mid-PAYLOAD, then reset_n low async between edges -> all outputs 0 immediately;
//     after release, A5 01 55 54 -> frame_ok, rd_data[0]=55.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind uart_receive: SOF, LEN, LEN payload bytes, XOR checksum.
// Good frames are committed to a readable bank; bad or stalled frames are dropped and flagged.
module uart_rx_frame_ctrl #(
    parameter int          CLK_HZ        = 50_000_000,
    parameter int          BAUD          = 9600,
    parameter logic [7:0]  SOF           = 8'hA5,
    parameter int          MAX_LEN       = 8,
    parameter int          TIMEOUT_BYTES = 4,
    localparam int         ADDR_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [3:0]        frame_len,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int BT     = 10 * CLK_HZ / BAUD;
    localparam int TO_CYC = TIMEOUT_BYTES * BT;
    localparam int TW     = $clog2(TO_CYC) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LEN     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_CHECK   = 2'd3;

    logic [1:0]    state;
    logic          byte_valid_d;
    logic          primed;
    logic [3:0]    len;
    logic [7:0]    csum;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_next;
    logic [TW-1:0] tcnt;
    logic [7:0]    shadow [MAX_LEN];
    logic [7:0]    bank   [MAX_LEN];

    logic accept;
    logic len_ok;
    logic timeout_hit;

    // Handshake: byte_in is sampled on the rising edge of byte_valid; there is no backpressure.
    // primed blocks a byte_valid that is already high when reset releases.
    assign accept      = byte_valid & ~byte_valid_d & primed;
    assign len_ok      = (byte_in >= 8'd1) && (byte_in <= 8'(MAX_LEN));
    assign busy        = (state != S_IDLE);
    assign idx_next    = idx + 1'b1;
    assign timeout_hit = busy && !accept && (tcnt >= TO_LAST);

    always_comb begin
        rd_data = 8'h00;
        if (int'(rd_addr) < MAX_LEN) rd_data = bank[rd_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            byte_valid_d <= 1'b0;
            primed       <= 1'b0;
            len          <= 4'd0;
            csum         <= 8'h00;
            idx          <= '0;
            tcnt         <= '0;
            frame_len    <= 4'd0;
            frame_ok     <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= 2'b00;
            for (int i = 0; i < MAX_LEN; i++) begin
                shadow[i] <= 8'h00;
                bank[i]   <= 8'h00;
            end
        end else begin
            byte_valid_d <= byte_valid;
            primed       <= 1'b1;
            frame_ok     <= 1'b0;
            frame_err    <= 1'b0;

            if (!busy || accept) tcnt <= '0;
            else if (tcnt != {TW{1'b1}}) tcnt <= tcnt + 1'b1;

            if (timeout_hit) begin
                frame_err <= 1'b1;
                err_code  <= 2'b11;
                state     <= S_IDLE;
            end else if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (byte_in == SOF) state <= S_LEN;
                    end
                    S_LEN: begin
                        if (len_ok) begin
                            len   <= byte_in[3:0];
                            csum  <= byte_in;
                            idx   <= '0;
                            state <= S_PAYLOAD;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b01;
                            state     <= S_IDLE;
                        end
                    end
                    S_PAYLOAD: begin
                        shadow[idx[ADDR_W-1:0]] <= byte_in;
                        csum <= csum ^ byte_in;
                        idx  <= idx_next;
                        if (idx_next == (ADDR_W+1)'(len)) state <= S_CHECK;
                    end
                    default: begin
                        if (byte_in == csum) begin
                            for (int i = 0; i < MAX_LEN; i++)
                                bank[i] <= (i < int'(len)) ? shadow[i] : 8'h00;
                            frame_len <= len;
                            frame_ok  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b10;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; a short byte time keeps the timeout scenario brief.
module tb_uart_rx_frame_ctrl;

    localparam int CLK_HZ  = 96_000;
    localparam int BAUD    = 9600;
    localparam int BT      = 10 * CLK_HZ / BAUD;
    localparam int TO      = 4 * BT;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic [3:0] frame_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int ok_cnt = 0;
    int err_cnt = 0;

    uart_rx_frame_ctrl #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .SOF(8'hA5), .MAX_LEN(8), .TIMEOUT_BYTES(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_len(frame_len), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle strobe: accepted on the posedge after the rise; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic send_byte_hold(input logic [7:0] b, input int n);
        @(negedge clock);
        byte_in    = b;
        byte_valid = 1'b1;
        repeat (n) @(negedge clock);
        byte_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic check_bank(input string name, input logic [7:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== exp[i]) begin
                n_errors++;
                $display("FAIL %s rd_data[%0d]: got %h expected %h", name, i, rd_data, exp[i]);
            end
        end
        rd_addr = 3'd0;
    endtask

    task automatic test_reset();
        logic [7:0] z [8] = '{default: 8'h00};
        reset_n    = 1'b0;
        byte_in    = 8'hA5;
        byte_valid = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_level_strobe busy: got %b expected 0", busy); end
        n_checks++;
        if ({frame_ok, frame_err} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses: got %b expected 00", {frame_ok, frame_err}); end
        n_checks++;
        if (err_code !== 2'b00) begin n_errors++; $display("FAIL reset_err_code: got %b expected 00", err_code); end
        n_checks++;
        if (frame_len !== 4'd0) begin n_errors++; $display("FAIL reset_frame_len: got %0d expected 0", frame_len); end
        check_bank("reset", z);
        byte_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_good_frame();
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_byte(8'hA5);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL good_busy_after_sof: got %b expected 1", busy); end
        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        n_checks++;
        if (frame_ok !== 1'b0) begin n_errors++; $display("FAIL good_early_ok: got %b expected 0", frame_ok); end
        send_byte(8'h03);
        n_checks++;
        if (frame_ok !== 1'b1) begin n_errors++; $display("FAIL good_ok_pulse: got %b expected 1", frame_ok); end
        n_checks++;
        if (frame_len !== 4'd3) begin n_errors++; $display("FAIL good_frame_len: got %0d expected 3", frame_len); end
        @(negedge clock);
        n_checks++;
        if (frame_ok !== 1'b0) begin n_errors++; $display("FAIL good_ok_width: got %b expected 0", frame_ok); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL good_busy_after: got %b expected 0", busy); end
        check_bank("good", exp);
    endtask

    task automatic test_bad_checksum();
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h00);
        n_checks++;
        if (frame_err !== 1'b1 || frame_ok !== 1'b0) begin n_errors++; $display("FAIL csum_err_pulse: got err=%b ok=%b expected err=1 ok=0", frame_err, frame_ok); end
        n_checks++;
        if (err_code !== 2'b10) begin n_errors++; $display("FAIL csum_err_code: got %b expected 10", err_code); end
        n_checks++;
        if (frame_len !== 4'd3) begin n_errors++; $display("FAIL csum_frame_len: got %0d expected 3", frame_len); end
        @(negedge clock);
        check_bank("csum", exp);
    endtask

    task automatic test_bad_len();
        logic [7:0] exp [8] = '{8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_byte(8'hA5); send_byte(8'h00);
        n_checks++;
        if (frame_err !== 1'b1 || err_code !== 2'b01) begin n_errors++; $display("FAIL len0: got err=%b code=%b expected err=1 code=01", frame_err, err_code); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL len0_busy: got %b expected 0", busy); end
        send_byte(8'hA5); send_byte(8'h09);
        n_checks++;
        if (frame_err !== 1'b1 || err_code !== 2'b01) begin n_errors++; $display("FAIL len9: got err=%b code=%b expected err=1 code=01", frame_err, err_code); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL len9_busy: got %b expected 0", busy); end
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C); send_byte(8'hFD);
        n_checks++;
        if (frame_ok !== 1'b1 || frame_len !== 4'd2) begin n_errors++; $display("FAIL len_recover: got ok=%b len=%0d expected ok=1 len=2", frame_ok, frame_len); end
        @(negedge clock);
        check_bank("len_recover", exp);
    endtask

    task automatic test_timeout();
        int first = -1;
        int seen = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        for (int k = 1; k <= TO + 5; k++) begin
            @(negedge clock);
            if (frame_err && first < 0) first = k;
        end
        n_checks++;
        if (first !== TO) begin n_errors++; $display("FAIL timeout_cycle: got %0d expected %0d", first, TO); end
        n_checks++;
        if (err_code !== 2'b11 || busy !== 1'b0) begin n_errors++; $display("FAIL timeout_state: got code=%b busy=%b expected code=11 busy=0", err_code, busy); end
        n_checks++;
        if (frame_len !== 4'd2) begin n_errors++; $display("FAIL timeout_frame_len: got %0d expected 2", frame_len); end

        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        for (int k = 1; k <= TO - 2; k++) begin
            @(negedge clock);
            if (frame_err) seen++;
        end
        send_byte(8'h22);
        if (frame_err) seen++;
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL timeout_byte_wins err: got %0d pulses expected 0", seen); end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL timeout_byte_wins busy: got %b expected 1", busy); end
        send_byte(8'h31);
        n_checks++;
        if (frame_ok !== 1'b1 || frame_len !== 4'd2) begin n_errors++; $display("FAIL timeout_continue: got ok=%b len=%0d expected ok=1 len=2", frame_ok, frame_len); end
        rd_addr = 3'd1;
        #1;
        n_checks++;
        if (rd_data !== 8'h22) begin n_errors++; $display("FAIL timeout_continue rd_data[1]: got %h expected 22", rd_data); end
        rd_addr = 3'd0;
        @(negedge clock);
    endtask

    task automatic test_noise_level();
        logic [7:0] exp [8] = '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        int ok0, err0;
        ok0  = ok_cnt;
        err0 = err_cnt;
        send_byte_hold(8'h00, 100); send_byte_hold(8'hFF, 100); send_byte_hold(8'h5A, 100);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL noise_busy: got %b expected 0", busy); end
        send_byte_hold(8'hA5, 100); send_byte_hold(8'h01, 100);
        send_byte_hold(8'h7E, 100); send_byte_hold(8'h7F, 100);
        @(negedge clock);
        #1;
        n_checks++;
        if (ok_cnt - ok0 !== 1) begin n_errors++; $display("FAIL level_ok_count: got %0d expected 1", ok_cnt - ok0); end
        n_checks++;
        if (err_cnt - err0 !== 0) begin n_errors++; $display("FAIL level_err_count: got %0d expected 0", err_cnt - err0); end
        n_checks++;
        if (frame_len !== 4'd1) begin n_errors++; $display("FAIL level_frame_len: got %0d expected 1", frame_len); end
        check_bank("level", exp);
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, frame_ok, frame_err, err_code, frame_len, rd_data} !== 17'd0) begin
            n_errors++;
            $display("FAIL async_reset outputs: got busy=%b ok=%b err=%b code=%b len=%0d rd=%h expected all 0",
                     busy, frame_ok, frame_err, err_code, frame_len, rd_data);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h54);
        n_checks++;
        if (frame_ok !== 1'b1 || frame_len !== 4'd1) begin n_errors++; $display("FAIL reset_recover: got ok=%b len=%0d expected ok=1 len=1", frame_ok, frame_len); end
        rd_addr = 3'd0;
        #1;
        n_checks++;
        if (rd_data !== 8'h55) begin n_errors++; $display("FAIL reset_recover rd_data[0]: got %h expected 55", rd_data); end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_len();
        test_timeout();
        test_noise_level();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
